sample_discriminator_config_scheduler: RTL

Sits between the PS configuration streams (after CDC into the ADC domain) and the sample discriminator. Stages threshold, delay, trigger-select and disable-mask words in shadow registers. On a commit, waits until all discriminator channels are idle, then applies every staged field in one cycle. It then holds the discriminator in its reset state for long enough to flush stale delay-line contents, so that no capture event ever straddles two configurations.

---
 rtl/sample_discriminator_config_scheduler.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sample_discriminator_config_scheduler.sv
// Configuration scheduler for the sample discriminator.
// Shadow registers stage threshold, delay, trigger-select and disable-mask words
// from the configuration streams. On commit the block waits for every channel to
// go idle (or for a drain timeout), applies all staged fields in a single cycle,
// then holds the discriminator in reset long enough to flush its delay lines.
// Each configuration stream is a flattened AXI-stream slave (tdata/tvalid/tready).
module sample_discriminator_config_scheduler #(
    parameter int CHANNELS         = 8,
    parameter int SAMPLE_WIDTH     = 16,
    parameter int MAX_DELAY_CYCLES = 64,
    parameter int TIMER_BITS       = $clog2(MAX_DELAY_CYCLES),
    parameter int SOURCE_BITS      = $clog2(8 + 8),
    parameter int DRAIN_TIMEOUT    = 256,
    parameter int FLUSH_CYCLES     = MAX_DELAY_CYCLES
) (
    input  logic                                   adc_clk,
    input  logic                                   adc_reset,

    input  logic [CHANNELS*2*SAMPLE_WIDTH-1:0]     adc_thresholds_tdata,
    input  logic                                   adc_thresholds_tvalid,
    output logic                                   adc_thresholds_tready,

    input  logic [CHANNELS*3*TIMER_BITS-1:0]       adc_delays_tdata,
    input  logic                                   adc_delays_tvalid,
    output logic                                   adc_delays_tready,

    input  logic [CHANNELS*SOURCE_BITS-1:0]        adc_trigger_select_tdata,
    input  logic                                   adc_trigger_select_tvalid,
    output logic                                   adc_trigger_select_tready,

    input  logic [CHANNELS-1:0]                    adc_disable_discriminator_tdata,
    input  logic                                   adc_disable_discriminator_tvalid,
    output logic                                   adc_disable_discriminator_tready,

    input  logic                                   adc_commit,
    input  logic [CHANNELS-1:0]                    adc_channel_active,

    output logic [CHANNELS*2*SAMPLE_WIDTH-1:0]     adc_thresholds_out,
    output logic [CHANNELS*3*TIMER_BITS-1:0]       adc_delays_out,
    output logic [CHANNELS*SOURCE_BITS-1:0]        adc_trigger_select_out,
    output logic [CHANNELS-1:0]                    adc_disable_out,
    output logic                                   adc_reset_state,
    output logic                                   adc_config_applied,
    output logic                                   adc_config_pending,
    output logic                                   adc_drain_timeout
);

    localparam int THR_W = CHANNELS * 2 * SAMPLE_WIDTH;
    localparam int DLY_W = CHANNELS * 3 * TIMER_BITS;
    localparam int SRC_W = CHANNELS * SOURCE_BITS;

    // Drain counter is at least 9 bits so the default 256-cycle limit fits.
    localparam int DRAIN_BITS = ($clog2(DRAIN_TIMEOUT + 1) > 9) ? $clog2(DRAIN_TIMEOUT + 1) : 9;
    localparam int FLUSH_BITS = ($clog2(FLUSH_CYCLES + 1) > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    localparam logic [DRAIN_BITS-1:0] DRAIN_LIMIT = DRAIN_BITS'(DRAIN_TIMEOUT);
    localparam logic [FLUSH_BITS-1:0] FLUSH_LAST  = FLUSH_BITS'(FLUSH_CYCLES - 1);

    // Staged-bit positions
    localparam int ST_THR = 0;
    localparam int ST_DLY = 1;
    localparam int ST_SRC = 2;
    localparam int ST_DIS = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGED,
        S_DRAIN,
        S_APPLY,
        S_FLUSH
    } state_t;

    state_t                  state_q, state_d;
    logic [THR_W-1:0]        thr_shadow_q, thr_shadow_d;
    logic [DLY_W-1:0]        dly_shadow_q, dly_shadow_d;
    logic [SRC_W-1:0]        src_shadow_q, src_shadow_d;
    logic [CHANNELS-1:0]     dis_shadow_q, dis_shadow_d;
    logic [3:0]              staged_q, staged_d;
    logic [THR_W-1:0]        thr_out_q, thr_out_d;
    logic [DLY_W-1:0]        dly_out_q, dly_out_d;
    logic [SRC_W-1:0]        src_out_q, src_out_d;
    logic [CHANNELS-1:0]     dis_out_q, dis_out_d;
    logic [DRAIN_BITS-1:0]   drain_cnt_q, drain_cnt_d;
    logic [FLUSH_BITS-1:0]   flush_cnt_q, flush_cnt_d;
    logic                    reset_state_q, reset_state_d;
    logic                    applied_q, applied_d;
    logic                    pending_q, pending_d;
    logic                    timeout_q, timeout_d;
    logic                    post_reset_q, post_reset_d;

    logic                    cfg_window;
    logic [SRC_W-1:0]        default_sources;

    // Default trigger source of channel i is i.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_default_src
            assign default_sources[gi*SOURCE_BITS +: SOURCE_BITS] = SOURCE_BITS'(gi);
        end
    endgenerate

    // Streams are only accepted while nothing is draining, applying or flushing.
    assign cfg_window = (state_q == S_IDLE) || (state_q == S_STAGED);

    assign adc_thresholds_tready            = cfg_window;
    assign adc_delays_tready                = cfg_window;
    assign adc_trigger_select_tready        = cfg_window;
    assign adc_disable_discriminator_tready = cfg_window;

    assign adc_thresholds_out     = thr_out_q;
    assign adc_delays_out         = dly_out_q;
    assign adc_trigger_select_out = src_out_q;
    assign adc_disable_out        = dis_out_q;
    assign adc_reset_state        = reset_state_q;
    assign adc_config_applied     = applied_q;
    assign adc_config_pending     = pending_q;
    assign adc_drain_timeout      = timeout_q;

    // Next-state logic: staging, commit/drain decision, apply and flush sequencing.
    always_comb begin
        state_d      = state_q;
        thr_shadow_d = thr_shadow_q;
        dly_shadow_d = dly_shadow_q;
        src_shadow_d = src_shadow_q;
        dis_shadow_d = dis_shadow_q;
        staged_d     = staged_q;
        thr_out_d    = thr_out_q;
        dly_out_d    = dly_out_q;
        src_out_d    = src_out_q;
        dis_out_d    = dis_out_q;
        drain_cnt_d  = drain_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        applied_d    = 1'b0;
        timeout_d    = timeout_q;
        post_reset_d = post_reset_q;

        case (state_q)
            S_IDLE, S_STAGED: begin
                if (adc_thresholds_tvalid) begin
                    thr_shadow_d     = adc_thresholds_tdata;
                    staged_d[ST_THR] = 1'b1;
                end
                if (adc_delays_tvalid) begin
                    dly_shadow_d     = adc_delays_tdata;
                    staged_d[ST_DLY] = 1'b1;
                end
                if (adc_trigger_select_tvalid) begin
                    src_shadow_d     = adc_trigger_select_tdata;
                    staged_d[ST_SRC] = 1'b1;
                end
                if (adc_disable_discriminator_tvalid) begin
                    dis_shadow_d     = adc_disable_discriminator_tdata;
                    staged_d[ST_DIS] = 1'b1;
                end
                // A write accepted in the commit cycle is part of the commit.
                if (adc_commit && (|staged_d)) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                    timeout_d   = 1'b0;
                end else if (|staged_d) begin
                    state_d = S_STAGED;
                end
            end
            S_DRAIN: begin
                // Idle channels win over a simultaneous timeout.
                if (adc_channel_active == '0) begin
                    state_d = S_APPLY;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                    if (drain_cnt_d == DRAIN_LIMIT) begin
                        state_d   = S_APPLY;
                        timeout_d = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                if (staged_q[ST_THR]) thr_out_d = thr_shadow_q;
                if (staged_q[ST_DLY]) dly_out_d = dly_shadow_q;
                if (staged_q[ST_SRC]) src_out_d = src_shadow_q;
                if (staged_q[ST_DIS]) dis_out_d = dis_shadow_q;
                staged_d    = '0;
                flush_cnt_d = '0;
                state_d     = S_FLUSH;
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d      = S_IDLE;
                    applied_d    = !post_reset_q;
                    post_reset_d = 1'b0;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        reset_state_d = (state_d == S_FLUSH);
        pending_d     = |staged_d;
    end

    // State and output registers; reset starts a post-reset flush with defaults.
    always_ff @(posedge adc_clk) begin
        if (adc_reset) begin
            state_q       <= S_FLUSH;
            thr_shadow_q  <= '0;
            dly_shadow_q  <= '0;
            src_shadow_q  <= '0;
            dis_shadow_q  <= '0;
            staged_q      <= '0;
            thr_out_q     <= '0;
            dly_out_q     <= '0;
            src_out_q     <= default_sources;
            dis_out_q     <= '1;
            drain_cnt_q   <= '0;
            flush_cnt_q   <= '0;
            reset_state_q <= 1'b1;
            applied_q     <= 1'b0;
            pending_q     <= 1'b0;
            timeout_q     <= 1'b0;
            post_reset_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            thr_shadow_q  <= thr_shadow_d;
            dly_shadow_q  <= dly_shadow_d;
            src_shadow_q  <= src_shadow_d;
            dis_shadow_q  <= dis_shadow_d;
            staged_q      <= staged_d;
            thr_out_q     <= thr_out_d;
            dly_out_q     <= dly_out_d;
            src_out_q     <= src_out_d;
            dis_out_q     <= dis_out_d;
            drain_cnt_q   <= drain_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
            reset_state_q <= reset_state_d;
            applied_q     <= applied_d;
            pending_q     <= pending_d;
            timeout_q     <= timeout_d;
            post_reset_q  <= post_reset_d;
        end
    end

endmodule
